or_gate_checker: RTL
====================

# or_gate_checker

Self-checking stimulus/response stage that wraps the two-input OR gate. It drives the gate's `a`/`b` inputs through the full truth table and samples the gate output after a programmable settle time. Each sample is compared against `a|b`, and the block reports error count, first failing vector and pass/fail. It replaces hand-written delay sequences in the gate bench with a clocked, repeatable sweep.

## Interface
Parameters:
- `SETTLE_CYCLES`, 2: cycles between applying a vector and sampling `y`; legal 1..15.
- `PASSES`, 1: number of full 4-vector sweeps per run; legal 1..255.
- `ERR_W`, 4: width of the error counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `a` out 1: registered stimulus to the gate input `a`.
- `b` out 1: registered stimulus to the gate input `b`.
- `y` in 1: gate output under test.
- `busy` out 1: high from the cycle after `start` is accepted through the FINISH cycle.
- `done` out 1: one-cycle pulse in FINISH.
- `pass` out 1: set in FINISH when `err_count==0`; held until the next accepted `start`.
- `err_count` out ERR_W: mismatches this run; saturating.
- `fail_vec` out 2: `{a,b}` of the first mismatching vector.
- `fail_valid` out 1: `fail_vec` holds a captured vector.

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, FINISH.
- IDLE, with `start`=1:
  - Clear `err_count`, `pass`, `fail_valid` and `fail_vec`.
  - Set vector index to 0 and pass counter to 0.
  - Go to APPLY.
- APPLY (1 cycle): `{a,b}` registers load the vector index. The order is 00, 01, 10, 11. Go to SETTLE.
- SETTLE (`SETTLE_CYCLES` cycles): a down-counter is loaded on entry. Go to CHECK when it expires. `a`/`b` are stable.
- CHECK (1 cycle): compare `y` with `a|b`.
  - On mismatch, increment `err_count` and saturate at all-ones; no wrap.
  - On the first mismatch of the run, set `fail_vec={a,b}` and `fail_valid`=1.
  - Next state:
    - If the index is below 3: increment the index and go to APPLY.
    - If the index is 3 and the pass counter is below `PASSES`-1: set the index to 0, increment the pass counter, go to APPLY.
    - Otherwise: go to FINISH.
- FINISH (1 cycle): `done`=1 and `pass`=(`err_count`==0). Go to IDLE. `a`/`b` return to 0 on entry to IDLE.
- `start` while busy is ignored; it is neither queued nor restarted.
- `y` is treated as asynchronous to the stimulus only within the settle window. The block does not synchronise `y`.

## Timing
- Reset values:
  - `a`, `b`, `busy`, `done`, `pass`, `fail_valid` = 0.
  - `err_count` and `fail_vec` = 0.
  - State = IDLE.
- Reset asserted mid-run aborts immediately. No `done` pulse is produced, and results read as zero after release.
- Per vector: 1 + `SETTLE_CYCLES` + 1 cycles.
- Timing is counted from the edge that accepts `start` (edge 0):
  - `a`/`b` for vector 0 are valid after edge 1.
  - `done` is high in the cycle after edge `4*PASSES*(SETTLE_CYCLES+2)`.
- Results (`pass`, `err_count`, `fail_*`) are final when `done` is high. They hold until the next accepted `start`.
- A `start` held high through FINISH is accepted on the first IDLE cycle. Runs are therefore back-to-back with exactly one IDLE cycle between them.

## Configuration
- `OR_CHECK_STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK goes directly to FINISH and skips the remaining vectors and passes.
  - `err_count` is then 1, and `pass`=0.
- Not defined: the full sweep always runs, and all mismatches are counted.

## Test plan
- Correct gate (`y=a|b`), `SETTLE_CYCLES`=2, `PASSES`=1: `start` -> `done` in the cycle after edge 16; `pass`=1, `err_count`=0, `fail_valid`=0.
- `y` stuck at 0, `PASSES`=1 -> `err_count`=3, `fail_vec`=01, `fail_valid`=1, `pass`=0.
- AND gate substituted (`y=a&b`) -> `err_count`=2, `fail_vec`=01.
- `y` stuck at 0, `PASSES`=8, `ERR_W`=4 -> `err_count` saturates at 15 (not 24 mod 16). The same bench with `OR_CHECK_STOP_ON_FAIL_EN` defined -> `done` after the vector-01 CHECK, `err_count`=1.
- `start` pulsed again while `busy`, then `rst_n` asserted during SETTLE of vector 10:
  - The second `start` has no effect.
  - After reset, all outputs are 0 and the state is IDLE.
  - No `done` pulse is seen.
  - A fresh `start` completes normally.

Source files
------------

// File: rtl/or_gate_checker.sv
// Clocked truth-table sweep for a two-input OR gate: drives a/b, waits a settle window,
// compares y against a|b and reports error count, first failing vector and pass/fail.
// Optional macro OR_CHECK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module or_gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);
`ifdef OR_CHECK_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [7:0]       pass_cnt, pass_cnt_nxt;
    logic [3:0]       settle_cnt, settle_cnt_nxt;
    logic             a_nxt, b_nxt;
    logic             pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [1:0]       fail_vec_nxt;
    logic             fail_valid_nxt;
    logic             mismatch;

    // Error counter must stick at all-ones rather than wrapping back to a "clean" value.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign mismatch = (y != (a | b));
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            pass_cnt   <= pass_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_vec   <= fail_vec_nxt;
            fail_valid <= fail_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        pass_cnt_nxt   = pass_cnt;
        settle_cnt_nxt = settle_cnt;
        a_nxt          = a;
        b_nxt          = b;
        pass_nxt       = pass;
        err_nxt        = err_count;
        fail_vec_nxt   = fail_vec;
        fail_valid_nxt = fail_valid;

        case (state)
            IDLE: begin
                if (start) begin
                    err_nxt        = '0;
                    pass_nxt       = 1'b0;
                    fail_vec_nxt   = '0;
                    fail_valid_nxt = 1'b0;
                    idx_nxt        = '0;
                    pass_cnt_nxt   = '0;
                    state_nxt      = APPLY;
                end
            end
            APPLY: begin
                a_nxt          = idx[1];
                b_nxt          = idx[0];
                settle_cnt_nxt = SETTLE_LOAD;
                state_nxt      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
                    if (!fail_valid) begin
                        fail_vec_nxt   = {a, b};
                        fail_valid_nxt = 1'b1;
                    end
                end
                // pass is registered on entry to FINISH so it is valid alongside done.
                if (STOP_ON_FAIL && mismatch) begin
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = FINISH;
                end else if (idx != 2'd3) begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = APPLY;
                end else if (pass_cnt < LAST_PASS) begin
                    idx_nxt      = '0;
                    pass_cnt_nxt = pass_cnt + 8'd1;
                    state_nxt    = APPLY;
                end else begin
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
